// File: rtl/row_feeder.sv
// Row feeder for one systolic-array row: a small FIFO of activation words followed
// by an issue register and SKEW delay stages that align the row with its neighbours.
module row_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SKEW       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          in_first,
    output logic                          in_ready,
    input  logic                          feed_en,
    input  logic                          flush,
    output logic [DATA_WIDTH-1:0]         row_input,
    output logic                          row_valid,
    output logic                          row_switch,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    // Handshake: a word moves upstream->buffer on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on feed_en or in_valid.

    logic [DATA_WIDTH-1:0] mem_data [0:FIFO_DEPTH-1];
    logic [FIFO_DEPTH-1:0] mem_first;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic                  rst_done;

    logic [DATA_WIDTH-1:0] st_data [0:SKEW];
    logic [SKEW:0]         st_first;
    logic [SKEW:0]         st_valid;

    logic push;
    logic pop;

    assign in_ready = rst_done && (level < LW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = feed_en && (level != '0) && !flush;

    // Storage carries no reset; validity is tracked entirely by level and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= in_data;
            mem_first[wr_ptr] <= in_first;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    // Stage 0 is the issue register; stages 1..SKEW shift every cycle regardless of feed_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
            st_first <= '0;
            for (int i = 0; i <= SKEW; i++) st_data[i] <= '0;
        end else if (flush) begin
            st_valid <= '0;
            st_first <= '0;
            for (int i = 0; i <= SKEW; i++) st_data[i] <= '0;
        end else begin
            st_valid[0] <= pop;
            st_first[0] <= pop && mem_first[rd_ptr];
            st_data[0]  <= pop ? mem_data[rd_ptr] : '0;
            for (int i = 1; i <= SKEW; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_first[i] <= st_first[i-1];
                st_data[i]  <= st_data[i-1];
            end
        end
    end

    assign row_valid  = st_valid[SKEW];
    assign row_input  = st_valid[SKEW] ? st_data[SKEW] : '0;
    assign row_switch = st_valid[SKEW] && st_first[SKEW];
    assign fifo_level = level;
    assign idle       = (level == '0) && (st_valid == '0);

endmodule

// File: tb/tb_row_feeder.sv
// Directed bench for row_feeder (SKEW=2, depth 4) with a queue-based output scoreboard.
module tb_row_feeder;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SK    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_first;
    logic          in_ready;
    logic          feed_en;
    logic          flush;
    logic [DW-1:0] row_input;
    logic          row_valid;
    logic          row_switch;
    logic [2:0]    fifo_level;
    logic          idle;

    int errors = 0;
    int checks = 0;
    logic [DW:0] exp_q[$];

    row_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SKEW(SK)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_first(in_first), .in_ready(in_ready), .feed_en(feed_en), .flush(flush),
        .row_input(row_input), .row_valid(row_valid), .row_switch(row_switch),
        .fifo_level(fifo_level), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (idle) break;
            tick();
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    // Scoreboard: compare the visible output, then record the word the next edge will accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (row_valid) begin
                check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    check("out_word", {15'd0, row_switch, row_input}, {15'd0, e});
                end
            end else begin
                check("bubble_zero", {15'd0, row_switch, row_input}, 32'd0);
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_first, in_data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_first = 1'b0;
        feed_en = 1'b0; flush = 1'b0;

        // Reset state
        #3;
        check("rst_row_valid", 32'(row_valid), 32'd0);
        check("rst_row_input", 32'(row_input), 32'd0);
        check("rst_row_switch", 32'(row_switch), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_edge_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single word, latency 1+SKEW, switch with the word
        feed_en = 1'b1; in_data = 16'h1234; in_first = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_first = 1'b0;
        check("lat_level1", 32'(fifo_level), 32'd1);
        tick();
        tick();
        check("lat_not_yet", 32'(row_valid), 32'd0);
        tick();
        check("lat_valid", 32'(row_valid), 32'd1);
        check("lat_data", 32'(row_input), 32'h1234);
        check("lat_switch", 32'(row_switch), 32'd1);
        tick();
        check("lat_one_cycle", 32'(row_valid), 32'd0);
        check("lat_switch_off", 32'(row_switch), 32'd0);
        check("lat_idle", 32'(idle), 32'd1);

        // Fill to full with feed_en low, fifth word held upstream
        feed_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'hA000 + 16'(i); in_first = (i == 0);
            tick();
        end
        in_data = 16'hA004; in_first = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(fifo_level), 32'd4);
        tick();
        tick();
        check("full_hold_level", 32'(fifo_level), 32'd4);
        feed_en = 1'b1;
        tick();
        check("drain_pop_only", 32'(fifo_level), 32'd3);
        tick();
        check("drain_push_pop", 32'(fifo_level), 32'd3);
        in_valid = 1'b0;
        wait_idle("drain_idle");

        // Continuous stream through a full buffer; pointers wrap repeatedly
        feed_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'hB000 + 16'(i);
            tick();
        end
        in_data = 16'hB004; feed_en = 1'b1;
        for (int n = 0; n < 10; n++) begin
            acc = in_ready;
            tick();
            check("stream_level", 32'((fifo_level == 3'd3) || (fifo_level == 3'd4)), 32'd1);
            if (acc) in_data = in_data + 16'd1;
        end
        in_valid = 1'b0;
        wait_idle("stream_idle");

        // Flush with 3 words buffered and 2 in the skew pipeline
        feed_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'hC000 + 16'(i);
            tick();
        end
        in_data = 16'hC004; feed_en = 1'b1;
        tick();
        tick();
        check("preflush_level", 32'(fifo_level), 32'd3);
        flush = 1'b1; in_data = 16'hC005;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_valid", 32'(row_valid), 32'd0);
        check("flush_idle", 32'(idle), 32'd1);
        repeat (4) begin
            tick();
            check("flush_quiet", 32'(row_valid), 32'd0);
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'hD000 + 16'(i);
            tick();
        end
        check("burst_valid", 32'(row_valid), 32'd1);
        #3;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("arst_valid", 32'(row_valid), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        check("arst_idle", 32'(idle), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            check("arst_no_old", 32'(row_valid), 32'd0);
        end
        in_valid = 1'b1; in_data = 16'hBEEF; in_first = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_idle("arst_new_idle");

        // feed_en 1,0,1 leaves a bubble between A and B
        feed_en = 1'b0;
        in_valid = 1'b1; in_data = 16'h00AA; in_first = 1'b0;
        tick();
        in_data = 16'h00BB; in_first = 1'b1;
        tick();
        in_valid = 1'b0; in_first = 1'b0;
        feed_en = 1'b1; tick();
        feed_en = 1'b0; tick();
        feed_en = 1'b1; tick();
        feed_en = 1'b0;
        check("gap_a_valid", 32'(row_valid), 32'd1);
        check("gap_a_data", 32'(row_input), 32'h00AA);
        check("gap_a_switch", 32'(row_switch), 32'd0);
        tick();
        check("gap_bubble_valid", 32'(row_valid), 32'd0);
        check("gap_bubble_data", 32'(row_input), 32'd0);
        check("gap_bubble_switch", 32'(row_switch), 32'd0);
        tick();
        check("gap_b_valid", 32'(row_valid), 32'd1);
        check("gap_b_data", 32'(row_input), 32'h00BB);
        check("gap_b_switch", 32'(row_switch), 32'd1);
        wait_idle("gap_idle");

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
